// File: rtl/camera_pkg.sv
// Shared definitions for the camera front end: RGB565 field layout,
// grayscale weights, default frame geometry and the conversion pipeline depth.
package camera_pkg;

    localparam int LINE_WIDTH_DEF = 640;
    localparam int NR_LINES_DEF   = 480;

    // Register stages in the gray converter.
    // Sync pulses are delayed by the same amount.
    localparam int PIPE_DEPTH = 2;

    // Luma weights, scaled by 256 (they sum to 256).
    localparam logic [7:0] COEF_R = 8'd77;
    localparam logic [7:0] COEF_G = 8'd150;
    localparam logic [7:0] COEF_B = 8'd29;

    // RGB565 word as sent by the camera: R in [15:11], G in [10:5], B in [4:0].
    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // Widen a channel to 8 bits by replicating its top bits into the LSBs.
    // This makes full scale map exactly to 255.
    function automatic logic [7:0] expand5(input logic [4:0] v);
        return {v, v[4:2]};
    endfunction

    function automatic logic [7:0] expand6(input logic [5:0] v);
        return {v, v[5:4]};
    endfunction

endpackage

// File: rtl/rgb565_to_gray.sv
// Two-stage pipelined RGB565 -> 8-bit gray converter.
// Ports: clock/reset (sync, active high), valid_i/pixel_i in, valid_o/gray_o out
// (PIPE_DEPTH cycles later). gray_o holds its value between valid strobes.
module rgb565_to_gray
    import camera_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_i,
    input  logic [15:0] pixel_i,
    output logic        valid_o,
    output logic [7:0]  gray_o
);

    rgb565_t px;
    logic [7:0] r8_q, r8_d, g8_q, g8_d, b8_q, b8_d;
    logic       v1_q, v1_d;
    logic [7:0] gray_q, gray_d;
    logic       v2_q, v2_d;
    logic [15:0] sum;

    assign px = rgb565_t'(pixel_i);

    // Weighted sum tops out at 256*255, so 16 bits never overflow
    // and the shifted result needs no saturation.
    assign sum = 16'(COEF_R) * 16'(r8_q)
               + 16'(COEF_G) * 16'(g8_q)
               + 16'(COEF_B) * 16'(b8_q);

    always_comb begin
        r8_d   = r8_q;
        g8_d   = g8_q;
        b8_d   = b8_q;
        v1_d   = valid_i;
        gray_d = gray_q;
        v2_d   = v1_q;
        if (valid_i) begin
            r8_d = expand5(px.r);
            g8_d = expand6(px.g);
            b8_d = expand5(px.b);
        end
        if (v1_q) begin
            gray_d = 8'(sum >> 8);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r8_q   <= '0;
            g8_q   <= '0;
            b8_q   <= '0;
            v1_q   <= 1'b0;
            gray_q <= '0;
            v2_q   <= 1'b0;
        end else begin
            r8_q   <= r8_d;
            g8_q   <= g8_d;
            b8_q   <= b8_d;
            v1_q   <= v1_d;
            gray_q <= gray_d;
            v2_q   <= v2_d;
        end
    end

    assign valid_o = v2_q;
    assign gray_o  = gray_q;

endmodule

// File: rtl/camera_gray_frontend.sv
// Camera byte stream to gray pixel stream with sync pulses and geometry checks.
// Ports: clock/reset (sync, active high); camVsync/camHref levels, camByteValid/camByte
// in; hsync/vsync pulses, validCamera/camData pixels, pixelCount/lineCount, sticky
// lineError/frameError out.
module camera_gray_frontend
    import camera_pkg::*;
#(
    parameter int LINE_WIDTH = LINE_WIDTH_DEF,
    parameter int NR_LINES   = NR_LINES_DEF,
    parameter int PIX_CNT_W  = 10,
    parameter int LINE_CNT_W = 9
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  camVsync,
    input  logic                  camHref,
    input  logic                  camByteValid,
    input  logic [7:0]            camByte,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  validCamera,
    output logic [7:0]            camData,
    output logic [PIX_CNT_W-1:0]  pixelCount,
    output logic [LINE_CNT_W-1:0] lineCount,
    output logic                  lineError,
    output logic                  frameError
);

    localparam logic [PIX_CNT_W-1:0]  LW = PIX_CNT_W'(LINE_WIDTH);
    localparam logic [LINE_CNT_W-1:0] NL = LINE_CNT_W'(NR_LINES);

    logic vsync_q, href_q;
    logic phase_q, phase_d;
    logic [7:0] hi_q, hi_d;
    logic [PIX_CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic [PIPE_DEPTH-1:0] hs_q, hs_d, vs_q, vs_d;
    logic line_err_q, line_err_d;
    logic frame_err_q, frame_err_d;
    logic armed_q, armed_d;

    logic vsync_fall, href_rise, href_fall;
    logic accept, pix_valid, line_nonempty;

    always_comb begin
        vsync_fall    = vsync_q & ~camVsync;
        href_rise     = ~href_q & camHref;
        href_fall     = href_q & ~camHref;
        accept        = camByteValid & camHref;
        line_nonempty = (pix_cnt_q != '0);

        // A new line always starts on a high byte; an odd trailing
        // byte is dropped when HREF falls.
        phase_d   = phase_q & ~href_rise & ~href_fall;
        hi_d      = hi_q;
        pix_valid = 1'b0;
        if (accept) begin
            if (phase_d) begin
                pix_valid = 1'b1;
                phase_d   = 1'b0;
            end else begin
                hi_d    = camByte;
                phase_d = 1'b1;
            end
        end

        pix_cnt_d = pix_cnt_q;
        if (href_rise) begin
            pix_cnt_d = '0;
        end else if (pix_valid && pix_cnt_q != '1) begin
            pix_cnt_d = pix_cnt_q + PIX_CNT_W'(1);
        end

        // Syncs ride a delay line as deep as the converter, so hsync
        // cannot overtake the last pixel of its line.
        hs_d = {hs_q[PIPE_DEPTH-2:0], href_fall & line_nonempty};
        vs_d = {vs_q[PIPE_DEPTH-2:0], vsync_fall};

        line_cnt_d = line_cnt_q;
        if (vsync_fall) begin
            line_cnt_d = '0;
        end else if (hs_q[PIPE_DEPTH-1]) begin
            line_cnt_d = line_cnt_q + LINE_CNT_W'(1);
        end

        // Checks start only after the first vsync fall seen since
        // reset; the frame in progress at reset is partial.
        armed_d     = armed_q | vsync_fall;
        line_err_d  = line_err_q
                    | (armed_q & href_fall & line_nonempty
                       & (pix_cnt_q != LW));
        frame_err_d = frame_err_q
                    | (armed_q & vsync_fall
                       & (line_cnt_q != '0) & (line_cnt_q != NL));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            phase_q     <= 1'b0;
            hi_q        <= '0;
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            hs_q        <= '0;
            vs_q        <= '0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            vsync_q     <= camVsync;
            href_q      <= camHref;
            phase_q     <= phase_d;
            hi_q        <= hi_d;
            pix_cnt_q   <= pix_cnt_d;
            line_cnt_q  <= line_cnt_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
            armed_q     <= armed_d;
        end
    end

    rgb565_to_gray u_gray (
        .clock   (clock),
        .reset   (reset),
        .valid_i (pix_valid),
        .pixel_i ({hi_q, camByte}),
        .valid_o (validCamera),
        .gray_o  (camData)
    );

    assign hsync      = hs_q[PIPE_DEPTH-1];
    assign vsync      = vs_q[PIPE_DEPTH-1];
    assign pixelCount = pix_cnt_q;
    assign lineCount  = line_cnt_q;
    assign lineError  = line_err_q;
    assign frameError = frame_err_q;

endmodule
